// File: rtl/uart_full_duplex_fifo.sv
// Full-duplex UART with a FIFO in each direction and a valid/ready handshake on each side.
// Baud divisor, data width, parity and stop bits are set by parameters.
// Each received word carries its own parity and framing error flags.
//
// state    | meaning (same encoding for TX and RX)
// IDLE     | line idle; TX waits for a FIFO word, RX waits for a start edge
// START    | start bit (TX drives 0, RX checks the middle of the bit)
// DATA     | data bits, LSB first
// PARITY   | parity bit, only used when PARITY_EN is set
// STOP     | stop bit(s); RX samples only the first one
module uart_full_duplex_fifo #(
    parameter int CLK_PER_BIT = 434,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_tx_valid,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx_ready,
    output logic                 o_tx,
    output logic                 o_tx_busy,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic                 o_rx_parity_err,
    output logic                 o_rx_frame_err,
    output logic                 o_rx_overrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(STOP_BITS * CLK_PER_BIT + 1);
    localparam int NW = $clog2(DATA_BITS);
    localparam int RW = DATA_BITS + 2;
    localparam logic [CW-1:0] C_BIT  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] C_STOP = CW'(STOP_BITS * CLK_PER_BIT - 1);
    localparam logic [NW-1:0] C_NBIT = NW'(DATA_BITS - 1);
    localparam logic P_EN  = (PARITY_EN != 0);
    localparam logic P_ODD = (PARITY_ODD != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
    logic [AW:0]          r_tx_wptr, r_tx_rptr;
    logic                 w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
    logic [DATA_BITS-1:0] w_tx_head;

    logic [2:0]           r_tx_state;
    logic [CW-1:0]        r_tx_cnt;
    logic [NW-1:0]        r_tx_nbit;
    logic [DATA_BITS-1:0] r_tx_sh;
    logic                 r_tx_par;
    logic                 r_tx;
    logic                 w_tx_line;

    assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
    assign w_tx_full  = (r_tx_wptr[AW] != r_tx_rptr[AW]) &&
                        (r_tx_wptr[AW-1:0] == r_tx_rptr[AW-1:0]);
    assign w_tx_head  = r_tx_mem[r_tx_rptr[AW-1:0]];
    // The FSM only pops from IDLE or the last STOP cycle, so a pop never depends on i_tx_valid.
    assign w_tx_pop   = !w_tx_empty &&
                        ((r_tx_state == S_IDLE) || ((r_tx_state == S_STOP) && (r_tx_cnt == '0)));
    assign o_tx_ready = !w_tx_full || w_tx_pop;
    assign w_tx_push  = i_tx_valid && o_tx_ready;
    assign o_tx_busy  = !((r_tx_state == S_IDLE) && w_tx_empty);
    assign o_tx       = r_tx;

    // TX FIFO storage write
    always_ff @(posedge i_clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr[AW-1:0]] <= i_tx_data;
    end

    // TX FIFO pointers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
        end
    end

    // Line level for the current TX state; registered below so the pin is glitch-free
    always_comb begin
        w_tx_line = 1'b1;
        case (r_tx_state)
            S_START:  w_tx_line = 1'b0;
            S_DATA:   w_tx_line = r_tx_sh[0];
            S_PARITY: w_tx_line = r_tx_par;
            default:  w_tx_line = 1'b1;
        endcase
    end

    // TX FSM: bit timing by down-counter, frames back-to-back while the FIFO has data
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_nbit  <= '0;
            r_tx_sh    <= '0;
            r_tx_par   <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_tx <= w_tx_line;
            if (w_tx_pop) begin
                r_tx_sh    <= w_tx_head;
                r_tx_par   <= ^w_tx_head ^ P_ODD;
                r_tx_state <= S_START;
                r_tx_cnt   <= C_BIT;
            end else begin
                case (r_tx_state)
                    S_START: begin
                        if (r_tx_cnt == '0) begin
                            r_tx_state <= S_DATA;
                            r_tx_cnt   <= C_BIT;
                            r_tx_nbit  <= C_NBIT;
                        end else r_tx_cnt <= r_tx_cnt - 1'b1;
                    end
                    S_DATA: begin
                        if (r_tx_cnt == '0) begin
                            r_tx_sh <= r_tx_sh >> 1;
                            if (r_tx_nbit == '0) begin
                                r_tx_state <= P_EN ? S_PARITY : S_STOP;
                                r_tx_cnt   <= P_EN ? C_BIT : C_STOP;
                            end else begin
                                r_tx_nbit <= r_tx_nbit - 1'b1;
                                r_tx_cnt  <= C_BIT;
                            end
                        end else r_tx_cnt <= r_tx_cnt - 1'b1;
                    end
                    S_PARITY: begin
                        if (r_tx_cnt == '0) begin
                            r_tx_state <= S_STOP;
                            r_tx_cnt   <= C_STOP;
                        end else r_tx_cnt <= r_tx_cnt - 1'b1;
                    end
                    S_STOP: begin
                        if (r_tx_cnt == '0) r_tx_state <= S_IDLE;
                        else                r_tx_cnt   <= r_tx_cnt - 1'b1;
                    end
                    default: r_tx_state <= S_IDLE;
                endcase
            end
        end
    end

    // ---------------- RX path ----------------
    logic          r_rx_s1, r_rx_s2, r_rx_d;
    logic          w_rx_fall;
    logic [2:0]    r_rx_state;
    logic [CW-1:0] r_rx_cnt;
    logic [NW-1:0] r_rx_nbit;
    logic [DATA_BITS-1:0] r_rx_sh;
    logic          r_rx_perr;
    logic          w_rx_push_req, w_rx_push, w_rx_pop, w_rx_empty, w_rx_full;
    logic [RW-1:0] r_rx_mem [FIFO_DEPTH];
    logic [AW:0]   r_rx_wptr, r_rx_rptr;
    logic [RW-1:0] w_rx_head;
    logic          r_rx_overrun;

    // Two-stage synchronizer plus one history stage for edge detection. A held-low
    // line (break) produces no new falling edge until it has been seen high again.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_rx_s1 <= i_rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
        end
    end

    assign w_rx_fall     = r_rx_d && !r_rx_s2;
    assign w_rx_push_req = (r_rx_state == S_STOP) && (r_rx_cnt == '0);

    // RX FSM: mid-bit sampling; returns to IDLE at the stop sample to absorb baud skew
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_nbit  <= '0;
            r_rx_sh    <= '0;
            r_rx_perr  <= 1'b0;
        end else begin
            case (r_rx_state)
                S_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_state <= S_START;
                        r_rx_cnt   <= C_HALF;
                        r_rx_perr  <= 1'b0;
                    end
                end
                S_START: begin
                    if (r_rx_cnt == '0) begin
                        r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
                        r_rx_cnt   <= C_BIT;
                        r_rx_nbit  <= C_NBIT;
                    end else r_rx_cnt <= r_rx_cnt - 1'b1;
                end
                S_DATA: begin
                    if (r_rx_cnt == '0) begin
                        r_rx_sh  <= {r_rx_s2, r_rx_sh[DATA_BITS-1:1]};
                        r_rx_cnt <= C_BIT;
                        if (r_rx_nbit == '0) r_rx_state <= P_EN ? S_PARITY : S_STOP;
                        else                 r_rx_nbit  <= r_rx_nbit - 1'b1;
                    end else r_rx_cnt <= r_rx_cnt - 1'b1;
                end
                S_PARITY: begin
                    if (r_rx_cnt == '0) begin
                        r_rx_perr  <= r_rx_s2 ^ (^r_rx_sh) ^ P_ODD;
                        r_rx_state <= S_STOP;
                        r_rx_cnt   <= C_BIT;
                    end else r_rx_cnt <= r_rx_cnt - 1'b1;
                end
                S_STOP: begin
                    if (r_rx_cnt == '0) r_rx_state <= S_IDLE;
                    else                r_rx_cnt   <= r_rx_cnt - 1'b1;
                end
                default: r_rx_state <= S_IDLE;
            endcase
        end
    end

    assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
    assign w_rx_full  = (r_rx_wptr[AW] != r_rx_rptr[AW]) &&
                        (r_rx_wptr[AW-1:0] == r_rx_rptr[AW-1:0]);
    assign w_rx_pop   = !w_rx_empty && i_rx_ready;
    // A pop in the same cycle frees the slot the new word lands in.
    assign w_rx_push  = w_rx_push_req && (!w_rx_full || w_rx_pop);
    assign w_rx_head  = r_rx_mem[r_rx_rptr[AW-1:0]];

    assign o_rx_valid      = !w_rx_empty;
    assign o_rx_data       = w_rx_head[RW-1:2];
    assign o_rx_parity_err = !w_rx_empty && w_rx_head[1];
    assign o_rx_frame_err  = !w_rx_empty && w_rx_head[0];
    assign o_rx_overrun    = r_rx_overrun;

    // RX FIFO storage write: {data, parity error, framing error}
    always_ff @(posedge i_clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wptr[AW-1:0]] <= {r_rx_sh, r_rx_perr, ~r_rx_s2};
    end

    // RX FIFO pointers and the one-cycle overrun pulse for a dropped word
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_wptr    <= '0;
            r_rx_rptr    <= '0;
            r_rx_overrun <= 1'b0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
            r_rx_overrun <= w_rx_push_req && !w_rx_push;
        end
    end
endmodule

// File: tb/tb_uart_full_duplex_fifo.sv
// Directed bench: instance A (8N1, loopback selectable), B (even parity), C (7 data bits, 2 stop).
module tb_uart_full_duplex_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // instance A
    logic       tx_valid_a = 1'b0;
    logic [7:0] tx_data_a  = '0;
    logic       tx_ready_a, tx_a, tx_busy_a;
    logic       rx_a;
    logic [7:0] rx_data_a;
    logic       rx_valid_a, perr_a, ferr_a, ovr_a;
    logic       rx_ready_a = 1'b0;
    logic       loop_a = 1'b1;
    logic       drv_a = 1'b1;
    assign rx_a = loop_a ? tx_a : drv_a;

    // instance B
    logic       tx_valid_b = 1'b0;
    logic [7:0] tx_data_b  = '0;
    logic       tx_ready_b, tx_b, tx_busy_b;
    logic       drv_b = 1'b1;
    logic [7:0] rx_data_b;
    logic       rx_valid_b, perr_b, ferr_b, ovr_b;
    logic       rx_ready_b = 1'b0;

    // instance C (loopback)
    logic       tx_valid_c = 1'b0;
    logic [6:0] tx_data_c  = '0;
    logic       tx_ready_c, tx_c, tx_busy_c;
    logic [6:0] rx_data_c;
    logic       rx_valid_c, perr_c, ferr_c, ovr_c;
    logic       rx_ready_c = 1'b0;

    uart_full_duplex_fifo #(.CLK_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                            .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .i_clk(clk), .i_rst(rst), .i_tx_valid(tx_valid_a), .i_tx_data(tx_data_a),
        .o_tx_ready(tx_ready_a), .o_tx(tx_a), .o_tx_busy(tx_busy_a), .i_rx(rx_a),
        .o_rx_data(rx_data_a), .o_rx_valid(rx_valid_a), .i_rx_ready(rx_ready_a),
        .o_rx_parity_err(perr_a), .o_rx_frame_err(ferr_a), .o_rx_overrun(ovr_a));

    uart_full_duplex_fifo #(.CLK_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                            .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
        .i_clk(clk), .i_rst(rst), .i_tx_valid(tx_valid_b), .i_tx_data(tx_data_b),
        .o_tx_ready(tx_ready_b), .o_tx(tx_b), .o_tx_busy(tx_busy_b), .i_rx(drv_b),
        .o_rx_data(rx_data_b), .o_rx_valid(rx_valid_b), .i_rx_ready(rx_ready_b),
        .o_rx_parity_err(perr_b), .o_rx_frame_err(ferr_b), .o_rx_overrun(ovr_b));

    uart_full_duplex_fifo #(.CLK_PER_BIT(16), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0),
                            .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
        .i_clk(clk), .i_rst(rst), .i_tx_valid(tx_valid_c), .i_tx_data(tx_data_c),
        .o_tx_ready(tx_ready_c), .o_tx(tx_c), .o_tx_busy(tx_busy_c), .i_rx(tx_c),
        .o_rx_data(rx_data_c), .o_rx_valid(rx_valid_c), .i_rx_ready(rx_ready_c),
        .o_rx_parity_err(perr_c), .o_rx_frame_err(ferr_c), .o_rx_overrun(ovr_c));

    // overrun pulse cycle counters
    int ovr_cnt_a  = 0;
    int ovr_cnt_bc = 0;
    always @(posedge clk) begin
        if (ovr_a) ovr_cnt_a <= ovr_cnt_a + 1;
        if (ovr_b || ovr_c) ovr_cnt_bc <= ovr_cnt_bc + 1;
    end

    logic cap_tx   [0:599];
    logic cap_busy [0:599];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_tx(input int inst, input logic v, input logic [7:0] d);
        case (inst)
            0:       begin tx_valid_a = v; tx_data_a = d;      end
            1:       begin tx_valid_b = v; tx_data_b = d;      end
            default: begin tx_valid_c = v; tx_data_c = d[6:0]; end
        endcase
    endtask

    task automatic set_ready(input int inst, input logic v);
        case (inst)
            0:       rx_ready_a = v;
            1:       rx_ready_b = v;
            default: rx_ready_c = v;
        endcase
    endtask

    task automatic set_line(input int inst, input logic v);
        if (inst == 0) drv_a = v;
        else           drv_b = v;
    endtask

    function automatic logic get_tx(input int inst);
        case (inst)
            0:       return tx_a;
            1:       return tx_b;
            default: return tx_c;
        endcase
    endfunction

    function automatic logic get_busy(input int inst);
        case (inst)
            0:       return tx_busy_a;
            1:       return tx_busy_b;
            default: return tx_busy_c;
        endcase
    endfunction

    // {valid, perr, ferr, data[7:0]}
    function automatic logic [10:0] get_rx(input int inst);
        case (inst)
            0:       return {rx_valid_a, perr_a, ferr_a, rx_data_a};
            1:       return {rx_valid_b, perr_b, ferr_b, rx_data_b};
            default: return {rx_valid_c, perr_c, ferr_c, 1'b0, rx_data_c};
        endcase
    endfunction

    // Writes nw words starting at capture slot 0 and records tx/busy at each falling edge.
    task automatic tx_capture(input int inst, input int nw, input logic [7:0] w0,
                              input logic [7:0] w1, input logic [7:0] w2, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            cap_tx[c]   = get_tx(inst);
            cap_busy[c] = get_busy(inst);
            if (c < nw) set_tx(inst, 1'b1, (c == 0) ? w0 : ((c == 1) ? w1 : w2));
            else        set_tx(inst, 1'b0, 8'h00);
        end
    endtask

    function automatic int first_low(input int ncyc);
        for (int c = 0; c < ncyc; c++) if (cap_tx[c] == 1'b0) return c;
        return -1;
    endfunction

    function automatic int low_len(input int start, input int ncyc);
        int n = 0;
        if (start < 0) return -1;
        for (int c = start; c < ncyc && cap_tx[c] == 1'b0; c++) n++;
        return n;
    endfunction

    function automatic int busy_count(input int ncyc);
        int n = 0;
        for (int c = 0; c < ncyc; c++) if (cap_busy[c]) n++;
        return n;
    endfunction

    // bits are LSB first, starting with the start bit; the line keeps the last bit afterwards
    task automatic send_frame(input int inst, input logic [15:0] bits, input int nb);
        for (int i = 0; i < nb; i++) begin
            set_line(inst, bits[i]);
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic pop_chk(input int inst, input string tag, input logic [7:0] d,
                           input logic p, input logic f);
        logic [10:0] r;
        r = get_rx(inst);
        chk({tag, "_valid"}, {31'd0, r[10]}, 32'd1);
        chk({tag, "_data"},  {24'd0, r[7:0]}, {24'd0, d});
        chk({tag, "_perr"},  {31'd0, r[9]}, {31'd0, p});
        chk({tag, "_ferr"},  {31'd0, r[8]}, {31'd0, f});
        set_ready(inst, 1'b1);
        @(negedge clk);
        set_ready(inst, 1'b0);
    endtask

    initial begin
        logic [7:0] words [3];
        logic       exp_bit;
        int         mism, fl, k, base;
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;

        // reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx", {31'd0, tx_a}, 32'd1);
        chk("rst_busy", {31'd0, tx_busy_a}, 32'd0);
        chk("rst_ready", {29'd0, tx_ready_a, tx_ready_b, tx_ready_c}, 32'd7);
        chk("rst_rx", {21'd0, get_rx(0)[10:8], 8'd0}, 32'd0);
        chk("rst_ovr", {31'd0, ovr_a}, 32'd0);

        // 1. loopback, three back-to-back frames
        tx_capture(0, 3, words[0], words[1], words[2], 513);
        fl = first_low(513);
        chk("t1_first_low", fl, 3);
        chk("t1_start_len", low_len(fl, 513), 16);
        mism = 0;
        for (int c = 0; c < 513; c++) begin
            exp_bit = 1'b1;
            if (c >= 3 && (c - 3) / 16 < 30) begin
                k = (c - 3) / 16;
                if (k % 10 == 0)      exp_bit = 1'b0;
                else if (k % 10 == 9) exp_bit = 1'b1;
                else                  exp_bit = words[k / 10][(k % 10) - 1];
            end
            if (cap_tx[c] !== exp_bit) mism++;
        end
        chk("t1_waveform_mism", mism, 0);
        chk("t1_busy_end", {31'd0, cap_busy[512]}, 32'd0);
        pop_chk(0, "t1_w0", 8'hA5, 1'b0, 1'b0);
        pop_chk(0, "t1_w1", 8'h3C, 1'b0, 1'b0);
        pop_chk(0, "t1_w2", 8'hFF, 1'b0, 1'b0);
        chk("t1_empty", {31'd0, rx_valid_a}, 32'd0);

        // 3. framing error followed by a break
        loop_a = 1'b0;
        repeat (4) @(negedge clk);
        send_frame(0, {6'b0, 1'b0, 8'h55, 1'b0}, 10);
        repeat (48) @(negedge clk);
        pop_chk(0, "t3_ferr", 8'h55, 1'b0, 1'b1);
        repeat (32) @(negedge clk);
        chk("t3_no_retrig_low", {31'd0, rx_valid_a}, 32'd0);
        set_line(0, 1'b1);
        repeat (32) @(negedge clk);
        chk("t3_no_word_high", {31'd0, rx_valid_a}, 32'd0);
        send_frame(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10);
        repeat (8) @(negedge clk);
        pop_chk(0, "t3_next", 8'h5A, 1'b0, 1'b0);

        // 4. overrun on the fifth frame
        base = ovr_cnt_a;
        for (int i = 1; i <= 5; i++) begin
            send_frame(0, {6'b0, 1'b1, 8'(i), 1'b0}, 10);
            if (i == 1) chk("t4_valid_first", {31'd0, rx_valid_a}, 32'd1);
            if (i == 4) chk("t4_no_ovr_yet", ovr_cnt_a - base, 0);
        end
        repeat (16) @(negedge clk);
        chk("t4_ovr_once", ovr_cnt_a - base, 1);
        for (int i = 1; i <= 4; i++) pop_chk(0, "t4_pop", 8'(i), 1'b0, 1'b0);
        chk("t4_empty", {31'd0, rx_valid_a}, 32'd0);

        // 5. glitch, then reset in the middle of a TX frame
        set_line(0, 1'b0);
        repeat (3) @(negedge clk);
        set_line(0, 1'b1);
        repeat (40) @(negedge clk);
        chk("t5_glitch", {31'd0, rx_valid_a}, 32'd0);
        send_frame(0, {6'b0, 1'b1, 8'h33, 1'b0}, 10);
        repeat (8) @(negedge clk);
        chk("t5_rx_before_rst", {31'd0, rx_valid_a}, 32'd1);
        set_tx(0, 1'b1, 8'h11);
        @(negedge clk);
        set_tx(0, 1'b1, 8'h22);
        @(negedge clk);
        set_tx(0, 1'b0, 8'h00);
        k = 0;
        while (tx_a && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t5_tx_started", {31'd0, tx_a}, 32'd0);
        repeat (16 * 4 + 8) @(negedge clk);
        chk("t5_busy_mid", {31'd0, tx_busy_a}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_tx", {31'd0, tx_a}, 32'd1);
        chk("t5_rst_busy", {31'd0, tx_busy_a}, 32'd0);
        chk("t5_rst_ready", {31'd0, tx_ready_a}, 32'd1);
        chk("t5_rst_rxv", {31'd0, rx_valid_a}, 32'd0);
        mism = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!tx_a || tx_busy_a) mism++;
        end
        chk("t5_fifo_empty", mism, 0);

        // 2. even parity: transmit and receive
        tx_capture(1, 1, 8'h07, 8'h00, 8'h00, 200);
        fl = first_low(200);
        chk("t2_first_low", fl, 3);
        chk("t2_bit2", {31'd0, cap_tx[59]}, 32'd1);
        chk("t2_bit3", {31'd0, cap_tx[75]}, 32'd0);
        chk("t2_parity_bit", {31'd0, cap_tx[155]}, 32'd1);
        chk("t2_stop_bit", {31'd0, cap_tx[171]}, 32'd1);
        chk("t2_busy_len", busy_count(200), 177);
        send_frame(1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        repeat (8) @(negedge clk);
        pop_chk(1, "t2_bad_par", 8'h07, 1'b1, 1'b0);
        send_frame(1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
        repeat (8) @(negedge clk);
        pop_chk(1, "t2_good_par", 8'h07, 1'b0, 1'b0);

        // 6. seven data bits, two stop bits
        tx_capture(2, 1, 8'h7F, 8'h00, 8'h00, 200);
        fl = first_low(200);
        chk("t6_first_low", fl, 3);
        chk("t6_start_len", low_len(fl, 200), 16);
        chk("t6_busy_len", busy_count(200), 161);
        pop_chk(2, "t6_loop", 8'h7F, 1'b0, 1'b0);
        chk("t6_ovr_bc", ovr_cnt_bc, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_full_duplex_fifo.md
Name: uart_full_duplex_fifo

Overview:
- Parametrised successor to the fixed 8N1 full-duplex UART.
- Independent TX and RX paths share one clock and have configurable baud divisor, data width, parity and stop bits.
- Each direction is buffered by a FIFO with a valid/ready handshake.
- RX errors (parity, framing, overrun) are reported per word.
- Sits between the system bus/CPU glue and the board serial pins.

Parameters:
- CLK_PER_BIT, 434: clk cycles per bit; must be >= 8.
- DATA_BITS, 8: data bits per frame; legal 5..9.
- PARITY_EN, 0: 1 inserts/checks a parity bit after the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
- STOP_BITS, 1: number of stop bits transmitted, 1 or 2. RX checks only the first stop bit.
- FIFO_DEPTH, 16: entries per FIFO; must be a power of 2, >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tx_valid  in  1  write request into TX FIFO.
- tx_data  in  DATA_BITS  word to transmit.
- tx_ready  out  1  TX FIFO not full.
- tx  out  1  serial output; idles high.
- tx_busy  out  1  a frame is on the line or the TX FIFO is non-empty.
- rx  in  1  serial input; asynchronous.
- rx_data  out  DATA_BITS  head of RX FIFO.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  pop RX FIFO.
- rx_parity_err  out  1  parity error flag of the head word; valid while rx_valid.
- rx_frame_err  out  1  framing error flag of the head word (first stop bit sampled 0); valid while rx_valid.
- rx_overrun  out  1  one-cycle pulse when a received word is dropped because the RX FIFO is full.

Behaviour:
- Reset (one clock, synchronous), all paths, including mid-frame:
  - tx = 1, tx_busy = 0, tx_ready = 1.
  - rx_valid = 0, rx_overrun = 0; error flags = 0.
  - Both FIFOs empty; both FSMs in IDLE; the in-flight frame is abandoned.
- Handshakes:
  - Write is accepted when tx_valid & tx_ready at a rising edge.
  - Pop occurs when rx_valid & rx_ready. rx_data and flags are combinational from the FIFO head and change the cycle after a pop.
- FIFOs:
  - Pointers are log2(FIFO_DEPTH)+1 bits; full/empty are decided by the MSB compare. Wrap-around must be seamless.
  - A simultaneous push and pop when full succeeds for the TX FIFO: tx_ready stays 1 and the count is unchanged.
  - A simultaneous push and pop when empty is a normal push.
  - The RX FIFO entry width is DATA_BITS+2 (data, perr, ferr).
- TX FSM:
  - States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
  - IDLE pops the FIFO when it is non-empty. A write at edge N into an empty FIFO while idle drives tx = 0 from edge N+2.
  - Each bit lasts exactly CLK_PER_BIT cycles. Data goes LSB first.
  - Parity = XOR of data bits, XOR PARITY_ODD.
  - STOP holds tx = 1 for STOP_BITS*CLK_PER_BIT cycles.
  - If the FIFO is non-empty at the end of STOP, the next START follows with no extra idle cycle (back-to-back frames).
  - tx_busy is 0 only when in IDLE with the FIFO empty.
- RX input conditioning: rx passes through a 2-FF synchronizer, reset value 1. All detection uses the synchronized signal.
- RX FSM:
  - States: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
  - IDLE: a synchronized 1->0 transition starts a counter.
  - START: at CLK_PER_BIT/2 the line is re-sampled. If high, it is a glitch: return to IDLE, push nothing.
  - DATA / PARITY / STOP: each bit is sampled every CLK_PER_BIT cycles after the mid-start sample.
  - At the STOP sample, the word is pushed with perr (PARITY_EN only) and ferr. Words with errors are still pushed.
  - If the RX FIFO is full at the push cycle, the word is discarded and rx_overrun pulses for 1 cycle. A pop in the same cycle frees space, so no overrun occurs.
  - After STOP the FSM returns to IDLE immediately, ready for a start edge half a bit early. This tolerates ±4% baud mismatch.
  - A frame-errored word whose line stays low (break) must not retrigger until rx has been seen high.
- TX and RX are fully independent; simultaneous activity is legal.

Test Plan:
All scenarios use CLK_PER_BIT=16, DATA_BITS=8, FIFO_DEPTH=4 unless stated.
1. Loopback (tx tied to rx): write 0xA5, 0x3C, 0xFF back-to-back -> the same three words appear on rx_data in order with flags 0. The tx low period of the first start bit is exactly 16 cycles; frames have no idle gap.
2. PARITY_EN=1, PARITY_ODD=0: send 0x07 -> parity bit 1 on tx. Inject a frame for 0x07 with parity bit 0 -> word pushed, rx_parity_err=1.
3. Frame error: drive a frame for 0x55 with stop bit 0 and the line held low 3 bit times -> one word pushed with rx_frame_err=1. No second word until the line returns high and a new start arrives.
4. Overrun: receive 5 frames with rx_ready=0 -> rx_valid=1 after the first, the FIFO holds the first 4, and rx_overrun pulses exactly once on frame 5. Then pop 4 words -> 0x01..0x04.
5. Glitch and reset: a 3-cycle low pulse on rx -> no word pushed. Assert rst at mid-bit 4 of a TX frame -> tx=1, tx_busy=0, tx_ready=1 on the next cycle, and the FIFO is empty.
6. DATA_BITS=7, STOP_BITS=2: send 0x7F -> frame is 10 bit times long (start, 7 data, 2 stop), with tx high for 32 cycles at the end.
